// File: rtl/cpu_step_ctrl_if.sv
// Control bundle between the front-panel/CPU side and the step controller.
interface cpu_step_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             key_step_n;
    logic             sw_run;
    logic             halt;
    logic             cpu_tick;
    logic             run_mode;
    logic             halted;
    logic [CNT_W-1:0] tick_count;

    modport master (
        output key_step_n, sw_run, halt,
        input  cpu_tick, run_mode, halted, tick_count
    );

    modport slave (
        input  key_step_n, sw_run, halt,
        output cpu_tick, run_mode, halted, tick_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: debounced single-step or free-run ticking,
// frozen by a CPU halt request until reset.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 50_000_000,
    parameter int CNT_W           = 32
) (
    input logic            clock_in,
    input logic            reset,
    cpu_step_ctrl_if.slave io
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = $clog2(RUN_DIV + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_STEP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    logic key_s1, key_s2, run_s1, run_s2;
    logic key_lvl;
    logic key_db, key_db_d, run_db;
    logic [DB_W-1:0] key_cnt, run_cnt;
    logic [1:0] warm;
    logic armed;
    logic key_press;

    state_t state, state_nx;
    logic [PS_W-1:0] pre, pre_nx;
    logic tick_nx;
    logic tick_q, run_q, halt_q;
    logic [CNT_W-1:0] count_q;

    assign key_lvl = ~key_s2;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            key_s1 <= io.key_step_n;
            key_s2 <= key_s1;
            run_s1 <= io.sw_run;
            run_s2 <= run_s1;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            key_db   <= 1'b0;
            key_db_d <= 1'b0;
            key_cnt  <= '0;
            run_db   <= 1'b0;
            run_cnt  <= '0;
        end else begin
            key_db_d <= key_db;
            if (key_lvl == key_db) begin
                key_cnt <= '0;
            end else if (key_cnt == DB_LAST) begin
                key_db  <= key_lvl;
                key_cnt <= '0;
            end else begin
                key_cnt <= key_cnt + DB_W'(1);
            end
            if (run_s2 == run_db) begin
                run_cnt <= '0;
            end else if (run_cnt == DB_LAST) begin
                run_db  <= run_s2;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + DB_W'(1);
            end
        end
    end

    // Presses are only honoured once a genuine released sample has been
    // seen, so a key held across reset cannot produce a tick.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            if (warm[1] && key_s2 && !key_db)
                armed <= 1'b1;
        end
    end

    assign key_press = key_db & ~key_db_d & armed;

    always_comb begin
        state_nx = state;
        pre_nx   = '0;
        tick_nx  = 1'b0;
        unique case (state)
            S_STEP: begin
                if (io.halt)
                    state_nx = S_HALT;
                else if (run_db)
                    state_nx = S_RUN;
                else
                    tick_nx = key_press;
            end
            S_RUN: begin
                if (io.halt)
                    state_nx = S_HALT;
                else if (!run_db)
                    state_nx = S_STEP;
                else if (pre == PS_LAST)
                    tick_nx = 1'b1;
                else
                    pre_nx = pre + PS_W'(1);
            end
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_STEP;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state   <= S_STEP;
            pre     <= '0;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
            halt_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state   <= state_nx;
            pre     <= pre_nx;
            tick_q  <= tick_nx;
            run_q   <= (state_nx == S_RUN);
            halt_q  <= (state_nx == S_HALT);
            count_q <= count_q + CNT_W'(tick_nx);
        end
    end

    assign io.cpu_tick   = tick_q;
    assign io.run_mode   = run_q;
    assign io.halted     = halt_q;
    assign io.tick_count = count_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus random front-panel
// activity, all checked every cycle against a behavioural model.
module tb_cpu_step_ctrl;
    localparam int D    = 4;
    localparam int DIV  = 5;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   e = 0;

    cpu_step_ctrl_if #(.CNT_W(W)) bus ();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .RUN_DIV(DIV),
        .CNT_W(W)
    ) dut (
        .clock_in(clk),
        .reset(rst),
        .io(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: modes as small integers (0 step, 1 run, 2 halt); run-mode
    // ticks fall on every DIV-th clock spent in run; debounce as run length.
    bit m_k1, m_k2, m_r1, m_r2;
    bit m_kdb, m_kdbd, m_rdb, m_armed, m_tick;
    bit m_kl, m_press, m_ntick;
    int m_kcnt, m_rcnt, m_edges, m_mode, m_inrun, m_nmode, m_ninrun;
    logic [W-1:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k1 = 1; m_k2 = 1; m_r1 = 0; m_r2 = 0;
            m_kdb = 0; m_kdbd = 0; m_rdb = 0; m_armed = 0; m_tick = 0;
            m_kcnt = 0; m_rcnt = 0; m_edges = 0;
            m_mode = 0; m_inrun = 0; m_cnt = '0;
        end else begin
            m_kl     = !m_k2;
            m_press  = m_kdb && !m_kdbd && m_armed;
            m_nmode  = m_mode;
            m_ninrun = m_inrun;
            m_ntick  = 0;
            if (m_mode == 0) begin
                if (bus.halt) m_nmode = 2;
                else if (m_rdb) begin m_nmode = 1; m_ninrun = 0; end
                else m_ntick = m_press;
            end else if (m_mode == 1) begin
                if (bus.halt) m_nmode = 2;
                else if (!m_rdb) m_nmode = 0;
                else begin
                    m_ninrun = m_inrun + 1;
                    m_ntick  = (m_ninrun % DIV) == 0;
                end
            end
            if (m_edges >= 2 && m_k2 && !m_kdb) m_armed = 1;
            m_kdbd = m_kdb;
            if (m_kl != m_kdb) begin
                m_kcnt++;
                if (m_kcnt == D) begin m_kdb = m_kl; m_kcnt = 0; end
            end else m_kcnt = 0;
            if (m_r2 != m_rdb) begin
                m_rcnt++;
                if (m_rcnt == D) begin m_rdb = m_r2; m_rcnt = 0; end
            end else m_rcnt = 0;
            m_k2 = m_k1; m_k1 = bus.key_step_n;
            m_r2 = m_r1; m_r1 = bus.sw_run;
            if (m_edges < 10) m_edges++;
            m_mode  = m_nmode;
            m_inrun = m_ninrun;
            m_tick  = m_ntick;
            m_cnt   = m_cnt + W'(m_ntick);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cpu_tick",   32'(bus.cpu_tick),   32'(m_tick));
        chk("run_mode",   32'(bus.run_mode),   32'(m_mode == 1));
        chk("halted",     32'(bus.halted),     32'(m_mode == 2));
        chk("tick_count", 32'(bus.tick_count), 32'(m_cnt));
    end

    task automatic step(input logic k, input logic r, input logic h);
        @(negedge clk);
        bus.key_step_n = k;
        bus.sw_run     = r;
        bus.halt       = h;
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.key_step_n = 1'b1;
        bus.sw_run = 1'b0;
        bus.halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(1'b1, 1'b0, 1'b0);
        e = 0;
    endtask

    initial begin
        int ticks, tick_at, prev, rm_at, hold;
        logic k, r, h;
        bus.key_step_n = 1'b1;
        bus.sw_run = 1'b0;
        bus.halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tick",  32'(bus.cpu_tick),   0);
        chk("reset_count", 32'(bus.tick_count), 0);
        chk("reset_run",   32'(bus.run_mode),   0);

        // Held key: one tick, seven clocks after the first low sample
        do_reset();
        ticks = 0; tick_at = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus.cpu_tick) begin ticks++; tick_at = e; end
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.cpu_tick) ticks++;
        end
        chk("t1_ticks", 32'(ticks), 1);
        chk("t1_tick_edge", 32'(tick_at), 7);
        chk("t1_count", 32'(bus.tick_count), 1);

        // Short glitches never pass the debouncer
        do_reset();
        ticks = 0;
        for (int n = 0; n < 10; n++) begin
            repeat (3) begin
                step(1'b0, 1'b0, 1'b0);
                if (bus.cpu_tick) ticks++;
            end
            repeat (3) begin
                step(1'b1, 1'b0, 1'b0);
                if (bus.cpu_tick) ticks++;
            end
        end
        chk("t2_ticks", 32'(ticks), 0);
        chk("t2_count", 32'(bus.tick_count), 0);

        // Free-run: entry at edge 7, ticks every DIV clocks, key ignored
        do_reset();
        ticks = 0; prev = 0; rm_at = 0;
        for (int i = 1; i <= 57; i++) begin
            step((i >= 20 && i <= 30) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            if (bus.run_mode && rm_at == 0) rm_at = e;
            if (bus.cpu_tick) begin
                if (prev != 0) chk("t3_gap", 32'(e - prev), DIV);
                prev = e;
                ticks++;
            end
        end
        chk("t3_run_edge", 32'(rm_at), 7);
        chk("t3_ticks", 32'(ticks), 10);
        chk("t3_count", 32'(bus.tick_count), 10);

        // Halt on the edge a tick is due
        for (int i = 58; i <= 61; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_tick", 32'(bus.cpu_tick), 0);
        chk("t4_halted", 32'(bus.halted), 1);
        chk("t4_run", 32'(bus.run_mode), 0);
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            step((i / 8) % 2 == 0, (i / 12) % 2 == 0, 1'b0);
            if (bus.cpu_tick) ticks++;
        end
        chk("t4_ticks", 32'(ticks), 0);
        chk("t4_still_halted", 32'(bus.halted), 1);
        chk("t4_count", 32'(bus.tick_count), 10);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 7 + DIV * 255; i++) step(1'b1, 1'b1, 1'b0);
        chk("t5_count_255", 32'(bus.tick_count), 255);
        repeat (DIV) step(1'b1, 1'b1, 1'b0);
        chk("t5_wrap_tick", 32'(bus.cpu_tick), 1);
        chk("t5_count_0", 32'(bus.tick_count), 0);
        repeat (DIV) step(1'b1, 1'b1, 1'b0);
        chk("t5_count_1", 32'(bus.tick_count), 1);

        // Asynchronous reset mid-prescale and mid-debounce, key held through it
        do_reset();
        for (int i = 1; i <= 13; i++) step(i >= 10 ? 1'b0 : 1'b1, 1'b1, 1'b0);
        chk("t6_pre_run", 32'(bus.run_mode), 1);
        chk("t6_pre_count", 32'(bus.tick_count), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_tick", 32'(bus.cpu_tick), 0);
        chk("t6_rst_run", 32'(bus.run_mode), 0);
        chk("t6_rst_halted", 32'(bus.halted), 0);
        chk("t6_rst_count", 32'(bus.tick_count), 0);
        @(negedge clk);
        @(negedge clk);
        bus.sw_run = 1'b0;
        rst = 1'b0;
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus.cpu_tick) ticks++;
        end
        chk("t6_held_ticks", 32'(ticks), 0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus.cpu_tick) ticks++;
        end
        chk("t6_repress_ticks", 32'(ticks), 1);
        chk("t6_count", 32'(bus.tick_count), 1);

        // Random front-panel activity against the model
        for (int s = 0; s < 6; s++) begin
            do_reset();
            k = 1'b1; r = 1'b0; hold = 0;
            for (int i = 0; i < 500; i++) begin
                if (hold == 0) begin
                    k = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) r = ~r;
                    hold = $urandom_range(1, 12);
                end
                hold--;
                h = ($urandom_range(0, 399) == 0);
                step(k, r, h);
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
